// File: rtl/shift_right_seq.sv
// Multi-cycle right shifter (SRL/SRA/SRLV/SRAV): shifts up to STEP bits per cycle.
// Optional rotate-right support is enabled by defining SHIFT_RIGHT_SEQ_ROTATE_EN.
module shift_right_seq #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned SHAMT_W = 5,
  parameter int unsigned STEP    = 1
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               Start,
  input  logic [DATA_W-1:0]  Unshifted,
  input  logic [SHAMT_W-1:0] Shamt,
  input  logic               Arith,
`ifdef SHIFT_RIGHT_SEQ_ROTATE_EN
  input  logic               Rotate,
`endif
  output logic               Busy,
  output logic               Done,
  output logic [DATA_W-1:0]  Shifted
);

  localparam logic [SHAMT_W-1:0] STEP_AMT = SHAMT_W'(STEP);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   work_q, work_d;
  logic [SHAMT_W-1:0]  cnt_q, cnt_d;
  logic                mode_q, mode_d;
  logic [DATA_W-1:0]   shifted_q, shifted_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                rot_c;

  logic [SHAMT_W-1:0]  k_c;
  logic [DATA_W-1:0]   fill_mask_c;
  logic [DATA_W-1:0]   step_res_c;

`ifdef SHIFT_RIGHT_SEQ_ROTATE_EN
  logic rot_q, rot_d;
  assign rot_c = rot_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) rot_q <= 1'b0;
    else        rot_q <= rot_d;
  end
`else
  assign rot_c = 1'b0;
`endif

  // Per-cycle step: k = min(STEP, cnt); vacated MSBs get the current MSB (sign) or zero.
  always_comb begin
    k_c         = (cnt_q < STEP_AMT) ? cnt_q : STEP_AMT;
    fill_mask_c = ~({DATA_W{1'b1}} >> k_c);
    if (rot_c)
      step_res_c = (work_q >> k_c) | (work_q << SHAMT_W'(DATA_W - 32'(k_c)));
    else if (mode_q && work_q[DATA_W-1])
      step_res_c = (work_q >> k_c) | fill_mask_c;
    else
      step_res_c = work_q >> k_c;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= ST_IDLE;
      work_q    <= '0;
      cnt_q     <= '0;
      mode_q    <= 1'b0;
      shifted_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      work_q    <= work_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      shifted_q <= shifted_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    shifted_d = shifted_q;
`ifdef SHIFT_RIGHT_SEQ_ROTATE_EN
    rot_d     = rot_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (Start) begin
          work_d  = Unshifted;
          cnt_d   = Shamt;
          mode_d  = Arith;
`ifdef SHIFT_RIGHT_SEQ_ROTATE_EN
          rot_d   = Rotate;
`endif
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (cnt_q != '0) begin
          work_d = step_res_c;
          cnt_d  = cnt_q - k_c;
        end else begin
          shifted_d = work_q;
          state_d   = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_SHIFT);
    done_d = (state_d == ST_DONE);
  end

  assign Busy    = busy_q;
  assign Done    = done_q;
  assign Shifted = shifted_q;

endmodule

// File: tb/tb_shift_right_seq.sv
// Directed self-checking bench for shift_right_seq (STEP=1, 32-bit).
module tb_shift_right_seq;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        Start;
  logic [31:0] Unshifted;
  logic [4:0]  Shamt;
  logic        Arith;
  logic        Busy;
  logic        Done;
  logic [31:0] Shifted;
`ifdef SHIFT_RIGHT_SEQ_ROTATE_EN
  logic        Rotate;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  shift_right_seq #(.DATA_W(32), .SHAMT_W(5), .STEP(1)) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .Start     (Start),
    .Unshifted (Unshifted),
    .Shamt     (Shamt),
    .Arith     (Arith),
`ifdef SHIFT_RIGHT_SEQ_ROTATE_EN
    .Rotate    (Rotate),
`endif
    .Busy      (Busy),
    .Done      (Done),
    .Shifted   (Shifted)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; drives a one-cycle Start pulse accepted on the next edge (edge 0).
  task automatic launch(input logic [31:0] u, input logic [4:0] s, input logic a, input logic r);
    Unshifted = u;
    Shamt     = s;
    Arith     = a;
`ifdef SHIFT_RIGHT_SEQ_ROTATE_EN
    Rotate    = r;
`else
    if (r) $display("rotate request ignored in shift-only build");
`endif
    Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    check("busy_after_accept", 32'(Busy), 32'd1);
    check("done_after_accept", 32'(Done), 32'd0);
  endtask

  // Counts edges after edge 'base' until Done; Shifted must stay at 'prev' while busy.
  task automatic wait_done(input string tag, input int base, input int exp_edge,
                           input logic [31:0] prev, input logic [31:0] exp_res);
    int edge_n = -1;
    for (int n = base + 1; n <= base + 100; n++) begin
      @(posedge Clk); #1;
      if (Done) begin
        edge_n = n;
        break;
      end
      check({tag, "_busy"}, 32'(Busy), 32'd1);
      check({tag, "_hold"}, Shifted, prev);
    end
    check({tag, "_edge"}, 32'(edge_n), 32'(exp_edge));
    check({tag, "_res"}, Shifted, exp_res);
    check({tag, "_busy_done"}, 32'(Busy), 32'd0);
  endtask

  task automatic idle_check(input string tag, input logic [31:0] exp_res);
    @(posedge Clk); #1;
    check({tag, "_idle_done"}, 32'(Done), 32'd0);
    check({tag, "_idle_busy"}, 32'(Busy), 32'd0);
    check({tag, "_idle_res"}, Shifted, exp_res);
  endtask

  initial begin
    Rst_n = 1'b1; Start = 1'b0; Unshifted = '0; Shamt = '0; Arith = 1'b0;
`ifdef SHIFT_RIGHT_SEQ_ROTATE_EN
    Rotate = 1'b0;
`endif
    // Asynchronous reset asserted between edges
    #2 Rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_shifted", Shifted, 32'h0);
    repeat (2) @(posedge Clk);
    @(negedge Clk); Rst_n = 1'b1;
    @(posedge Clk); #1;

    // Logical shift by 4
    launch(32'h8000_0010, 5'd4, 1'b0, 1'b0);
    wait_done("srl4", 0, 5, 32'h0, 32'h0800_0001);
    idle_check("srl4", 32'h0800_0001);

    // Arithmetic shift by 4
    launch(32'h8000_0010, 5'd4, 1'b1, 1'b0);
    wait_done("sra4", 0, 5, 32'h0800_0001, 32'hF800_0001);
    idle_check("sra4", 32'hF800_0001);

    // Arithmetic shift by 31
    launch(32'h8000_0000, 5'd31, 1'b1, 1'b0);
    wait_done("sra31", 0, 32, 32'hF800_0001, 32'hFFFF_FFFF);
    idle_check("sra31", 32'hFFFF_FFFF);

    // Logical shift by 31
    launch(32'h8000_0000, 5'd31, 1'b0, 1'b0);
    wait_done("srl31", 0, 32, 32'hFFFF_FFFF, 32'h0000_0001);
    idle_check("srl31", 32'h0000_0001);

    // Shamt=0 then back-to-back Start in the DONE cycle
    launch(32'hDEAD_BEEF, 5'd0, 1'b1, 1'b0);
    wait_done("sh0", 0, 1, 32'h0000_0001, 32'hDEAD_BEEF);
    launch(32'h0000_0100, 5'd8, 1'b0, 1'b0);
    wait_done("b2b", 0, 9, 32'hDEAD_BEEF, 32'h0000_0001);
    idle_check("b2b", 32'h0000_0001);

    // Start re-asserted during SHIFT is ignored
    launch(32'h8000_0010, 5'd4, 1'b0, 1'b0);
    Unshifted = 32'hFFFF_FFFF; Shamt = 5'd1; Arith = 1'b1; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    wait_done("ignore", 1, 5, 32'h0000_0001, 32'h0800_0001);
    idle_check("ignore", 32'h0800_0001);

    // Reset mid-SHIFT aborts with no Done
    launch(32'hFFFF_0000, 5'd12, 1'b1, 1'b0);
    repeat (2) @(posedge Clk);
    #2 Rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(Busy), 32'd0);
    check("midrst_done", 32'(Done), 32'd0);
    check("midrst_shifted", Shifted, 32'h0);
    @(posedge Clk);
    @(negedge Clk); Rst_n = 1'b1;
    for (int i = 0; i < 3; i++) idle_check("midrst", 32'h0);
    launch(32'hF000_0000, 5'd2, 1'b0, 1'b0);
    wait_done("postrst", 0, 3, 32'h0, 32'h3C00_0000);
    idle_check("postrst", 32'h3C00_0000);

`ifdef SHIFT_RIGHT_SEQ_ROTATE_EN
    // Rotate right by 4, Arith ignored
    launch(32'h0000_0013, 5'd4, 1'b1, 1'b1);
    wait_done("ror4", 0, 5, 32'h3C00_0000, 32'h3000_0001);
    idle_check("ror4", 32'h3000_0001);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_right_seq.md
Name: shift_right_seq

Overview:
- Multi-cycle right shifter for the MIPS datapath. Executes SRL, SRA, SRLV and SRAV. It is the right-shift counterpart to the existing combinational left-shift logic.
- Operands arrive with a Start pulse. The unit shifts STEP bit positions per cycle, then returns the result with a one-cycle Done pulse.
- Sits beside the ALU. The multi-cycle control FSM stalls on Busy.

Parameters:
- DATA_W, 32, operand and result width.
- SHAMT_W, 5, shift-amount width; must satisfy 2^SHAMT_W == DATA_W.
- STEP, 1, maximum bit positions shifted per cycle; legal values are 1, 2, 4, 8.

Ports:
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  asynchronous active-low reset.
- Start  input  1  request pulse; operands are sampled on the same edge.
- Unshifted  input  DATA_W  operand.
- Shamt  input  SHAMT_W  shift amount, unsigned.
- Arith  input  1  1 = arithmetic shift (sign fill); 0 = logical shift (zero fill).
- Busy  output  1  high while in SHIFT.
- Done  output  1  one-cycle pulse; Shifted is valid in that cycle.
- Shifted  output  DATA_W  result; held until the next accepted Start.

Behaviour:
- Reset: Rst_n low forces the following immediately, without waiting for Clk.
  - state=IDLE.
  - Busy=0, Done=0.
  - Shifted=0.
  - Internal work register=0, count=0, sign/mode flag=0.
- Reset mid-operation aborts the shift with no Done. Operation resumes in IDLE after Rst_n rises.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - Start=1 loads work<=Unshifted, cnt<=Shamt, mode<=Arith; next state SHIFT.
  - Start=0: remain in IDLE.
- SHIFT (Busy=1):
  - cnt!=0: work shifts right by k=min(STEP,cnt). Vacated MSBs are filled with work[DATA_W-1] if mode=1, else 0. cnt<=cnt-k. Stay in SHIFT.
  - cnt==0: Shifted<=work; next state DONE.
  - Start is ignored in SHIFT. Inputs are not re-sampled.
- DONE (Done=1 for exactly one cycle):
  - Start=1 is accepted as in IDLE (back-to-back); next state SHIFT.
  - Start=0: next state IDLE.
- Latency: call the accepting edge edge 0. Done is high in the cycle after edge ceil(Shamt/STEP)+1.
  - Shamt=0 gives Done after edge 1.
  - Shamt=31 with STEP=1 gives Done after edge 32.
- Shifted changes only on the edge entering DONE (or on reset). It is stable during IDLE and SHIFT.
- Sign fill uses the original operand MSB, preserved by shifting a copy of the sign into vacated bits each step. A result of all-ones from 0x80000000 with Shamt=31 is correct.
- Shamt is never reduced modulo anything beyond its width; the full 0..DATA_W-1 range is legal.
- Start with unknown operands is the caller's fault; no X-protection is required.

Optional Feature:
- Macro: SHIFT_RIGHT_SEQ_ROTATE_EN.
- Defined:
  - Adds input port Rotate (1 bit), sampled with Start.
  - Rotate=1 performs rotate-right: bits leaving the LSB re-enter at the MSB. Arith is ignored when Rotate=1.
  - Latency is identical to a shift of the same Shamt.
- Undefined:
  - Rotate port is absent.
  - Behaviour is shift-only, exactly as above.

Test Plan:
- Reset with Rst_n low, asserted asynchronously between edges -> Busy=0, Done=0, Shifted=0x00000000 immediately, before the next Clk edge.
- Start, Unshifted=0x80000010, Shamt=4, Arith=0 -> Shifted=0x08000001; Done after edge 5 (STEP=1); Busy high for edges 1–4.
- Same operands with Arith=1 -> Shifted=0xF8000001. Then Unshifted=0x80000000, Shamt=31, Arith=1 -> 0xFFFFFFFF, Done after edge 32.
- Shamt=0, Unshifted=0xDEADBEEF -> Shifted=0xDEADBEEF, Done after edge 1. Issue a second Start in the DONE cycle (0x00000100, Shamt=8, Arith=0) -> accepted; Shifted=0x00000001 after a further 9 edges.
- Start re-asserted during SHIFT with different operands -> ignored; first result is unchanged. Rst_n pulsed low mid-SHIFT -> no Done, outputs zero, next Start is processed normally.
- With SHIFT_RIGHT_SEQ_ROTATE_EN defined: Unshifted=0x00000013, Shamt=4, Rotate=1 -> Shifted=0x30000001. Rerun with STEP=4: same result, Done after edge 2.
